// File: rtl/dac_spi_mc.sv
// Multi-channel SPI DAC driver: coalescing per-channel shadows, round-robin flush, one-time init frame.
// Optional: define DAC_SYNC_UPDATE_EN to write input registers only and follow each burst with an update-all frame.
module dac_spi_mc #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_chan,
  input  logic [DATA_W-1:0] wr_value,
  output logic              busy,
  output logic              init_done,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
`ifdef DAC_SYNC_UPDATE_EN
  localparam logic [3:0] CMD_DATA = 4'b0000;
`else
  localparam logic [3:0] CMD_DATA = 4'b0011;
`endif

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;
  typedef enum logic [1:0] {F_INIT, F_DATA, F_UPD} fkind_t;

  state_t            state_reg, state_next;
  fkind_t            kind_reg, kind_next;
  logic [CH_W-1:0]   chan_reg, chan_next;
  logic [CH_W-1:0]   rr_ptr_reg;
  logic [31:0]       shift_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [6:0]        edge_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              cs_n_reg, sclk_reg, mosi_reg, init_done_reg;
  logic [DATA_W-1:0] shadow_val [NUM_CH];
  logic [NUM_CH-1:0] dirty_vec;
  logic              wr_accept, load_clr, found;
  logic [CH_W-1:0]   scan_chan;
  logic [11:0]       data12;
  logic [31:0]       frame;

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
    int k;
    k = int'(base) + off;
    if (k >= NUM_CH) k -= NUM_CH;
    return CH_W'(k);
  endfunction

  assign wr_accept = wr_valid && init_done_reg;
  assign load_clr  = (state_reg == S_LOAD) && (kind_reg == F_DATA);

  // A write in the same cycle as LOAD wins, so the channel stays dirty with its newest value.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] shadow_reg;
      logic              dirty_reg;
      logic              hit;
      assign hit = wr_accept && (wr_chan == CH_W'(gi));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg <= '0;
          dirty_reg  <= 1'b0;
        end else if (hit) begin
          shadow_reg <= wr_value;
          dirty_reg  <= 1'b1;
        end else if (load_clr && chan_reg == CH_W'(gi)) begin
          dirty_reg  <= 1'b0;
        end
      end
      assign shadow_val[gi] = shadow_reg;
      assign dirty_vec[gi]  = dirty_reg;
    end
  endgenerate

  always_comb begin
    found     = 1'b0;
    scan_chan = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && dirty_vec[wrap_add(rr_ptr_reg, i)]) begin
        found     = 1'b1;
        scan_chan = wrap_add(rr_ptr_reg, i);
      end
    end
  end

  always_comb begin
    data12 = 12'(shadow_val[chan_reg]);
    data12 = data12 << (12 - DATA_W);
    case (kind_reg)
      F_INIT:  frame = 32'h0800_0001;
      F_UPD:   frame = 32'h01F0_0000;
      default: frame = {4'h0, CMD_DATA, 4'(chan_reg), data12, 8'h00};
    endcase
  end

`ifdef DAC_SYNC_UPDATE_EN
  logic upd_pending_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) upd_pending_reg <= 1'b0;
    else if (state_reg == S_LOAD && kind_reg == F_DATA) upd_pending_reg <= 1'b1;
    else if (state_reg == S_LOAD && kind_reg == F_UPD) upd_pending_reg <= 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_INIT;
      kind_reg  <= F_INIT;
      chan_reg  <= '0;
    end else begin
      state_reg <= state_next;
      kind_reg  <= kind_next;
      chan_reg  <= chan_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    kind_next  = kind_reg;
    chan_next  = chan_reg;
    case (state_reg)
      S_INIT: begin
        state_next = S_LOAD;
        kind_next  = F_INIT;
      end
      S_IDLE: begin
        if (found) begin
          state_next = S_LOAD;
          kind_next  = F_DATA;
          chan_next  = scan_chan;
        end
`ifdef DAC_SYNC_UPDATE_EN
        else if (upd_pending_reg) begin
          state_next = S_LOAD;
          kind_next  = F_UPD;
        end
`endif
      end
      S_LOAD:  state_next = S_SHIFT;
      S_SHIFT: if (edge_cnt_reg == 7'd64 && div_cnt_reg == DIV_W'(CLK_DIV)) state_next = S_GAP;
      S_GAP:   if (gap_cnt_reg == GAP_W'(CS_GAP - 1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // After the 64th sclk toggle a tail of CLK_DIV+1 cycles keeps cs_n low past the last falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_reg      <= 1'b1;
      sclk_reg      <= 1'b0;
      mosi_reg      <= 1'b0;
      shift_reg     <= '0;
      div_cnt_reg   <= '0;
      edge_cnt_reg  <= '0;
      gap_cnt_reg   <= '0;
      rr_ptr_reg    <= '0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          shift_reg    <= frame;
          cs_n_reg     <= 1'b0;
          mosi_reg     <= frame[31];
          div_cnt_reg  <= '0;
          edge_cnt_reg <= '0;
          if (kind_reg == F_DATA) rr_ptr_reg <= wrap_add(chan_reg, 1);
        end
        S_SHIFT: begin
          if (edge_cnt_reg != 7'd64) begin
            if (div_cnt_reg == DIV_W'(CLK_DIV - 1)) begin
              div_cnt_reg  <= '0;
              sclk_reg     <= ~sclk_reg;
              edge_cnt_reg <= edge_cnt_reg + 7'd1;
              if (!sclk_reg && edge_cnt_reg != 7'd0) begin
                shift_reg <= shift_reg << 1;
                mosi_reg  <= shift_reg[30];
              end
            end else begin
              div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end
          end else if (div_cnt_reg == DIV_W'(CLK_DIV)) begin
            cs_n_reg    <= 1'b1;
            mosi_reg    <= 1'b0;
            gap_cnt_reg <= '0;
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        S_GAP: begin
          gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          if (gap_cnt_reg == GAP_W'(CS_GAP - 1) && kind_reg == F_INIT) init_done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != S_IDLE);
  assign init_done = init_done_reg;
  assign wr_ready  = init_done_reg;
  assign cs_n      = cs_n_reg;
  assign sclk      = sclk_reg;
  assign mosi      = mosi_reg;

endmodule

// File: tb/tb_dac_spi_mc.sv
// Directed bench for dac_spi_mc: decodes SPI frames on sclk falling edges and checks them against hand-computed words.
module tb_dac_spi_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_chan = '0;
  logic [11:0] wr_value = '0;
  logic        busy, init_done, cs_n, sclk, mosi;

  int total = 0;
  int bad = 0;

`ifdef DAC_SYNC_UPDATE_EN
  localparam logic [31:0] CMDX = 32'h0000_0000;
`else
  localparam logic [31:0] CMDX = 32'h0300_0000;
`endif
  localparam int LOW_CYC = 261;

  typedef struct {
    logic [31:0] data;
    int          bits;
    int          low;
  } frame_t;
  frame_t fq[$];

  dac_spi_mc #(.NUM_CH(8), .DATA_W(12), .CLK_DIV(4), .CS_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_chan(wr_chan), .wr_value(wr_value), .busy(busy), .init_done(init_done),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Frame monitor: samples on the clk falling edge, away from where the DUT updates.
  initial begin
    logic [31:0] sh = '0;
    int nbits = 0, nlow = 0, nfr = 0;
    logic prev_sclk = 1'b0, prev_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sh = '0; nbits = 0; nlow = 0;
        prev_cs = 1'b1;
      end else begin
        if (!cs_n) begin
          nlow++;
          if (prev_sclk && !sclk) begin
            sh = {sh[30:0], mosi};
            nbits++;
          end
        end else if (!prev_cs) begin
          fq.push_back('{data: sh, bits: nbits, low: nlow});
          $display("frame %0d: data=0x%08h bits=%0d cs_low=%0d", nfr, sh, nbits, nlow);
          nfr++;
          sh = '0; nbits = 0; nlow = 0;
        end
        prev_cs = cs_n;
      end
      prev_sclk = sclk;
    end
  end

  task automatic do_write(input int ch, input logic [11:0] v);
    int waited = 0;
    logic rdy = 1'b0;
    wr_chan  = 3'(ch);
    wr_value = v;
    wr_valid = 1'b1;
    while (!rdy && waited < 3000) begin
      @(negedge clk);
      rdy = wr_ready;
      waited++;
    end
    check_val($sformatf("wr_ack_ch%0d", ch), 32'(rdy), 32'd1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    $display("write: ch=%0d value=0x%03h", ch, v);
  endtask

  task automatic expect_frame(input string tag, input logic [31:0] exp);
    int waited = 0;
    frame_t f;
    while (fq.size() == 0 && waited < 3000) begin
      @(posedge clk);
      waited++;
    end
    check_val({tag, "_present"}, 32'(fq.size() > 0), 32'd1);
    if (fq.size() > 0) begin
      f = fq.pop_front();
      check_val({tag, "_data"}, f.data, exp);
      check_val({tag, "_bits"}, 32'(f.bits), 32'd32);
      check_val({tag, "_cslow"}, 32'(f.low), 32'(LOW_CYC));
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    repeat (cycles) @(negedge clk);
    check_val({tag, "_noframe"}, 32'(fq.size()), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    fq.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int waited;
    // Test 1: reset values, init frame, coalesced writes to ch5
    #3 rst_n = 1'b0;
    #1;
    check_val("rst_cs_n", 32'(cs_n), 32'd1);
    check_val("rst_sclk", 32'(sclk), 32'd0);
    check_val("rst_mosi", 32'(mosi), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd1);
    check_val("rst_init_done", 32'(init_done), 32'd0);
    check_val("rst_wr_ready", 32'(wr_ready), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_write(5, 12'h111);
    do_write(5, 12'h222);
    check_val("init_done_up", 32'(init_done), 32'd1);
    expect_frame("init1", 32'h0800_0001);
    expect_frame("ch5", CMDX | 32'h0052_2200);
`ifdef DAC_SYNC_UPDATE_EN
    expect_frame("upd1", 32'h01F0_0000);
`endif
    expect_quiet("t1", 600);

    // Test 2: single write ch3, busy during frame
    do_write(3, 12'hABC);
    waited = 0;
    while (cs_n && waited < 100) begin @(negedge clk); waited++; end
    check_val("busy_in_frame", 32'(busy), 32'd1);
    expect_frame("ch3", CMDX | 32'h003A_BC00);
`ifdef DAC_SYNC_UPDATE_EN
    expect_frame("upd2", 32'h01F0_0000);
`endif
    expect_quiet("t2", 600);

    // Test 3: round-robin order from rr_ptr=0 and wrap back to ch1
    apply_reset();
    do_write(1, 12'h111);
    do_write(6, 12'h666);
    do_write(2, 12'h222);
    do_write(1, 12'h123);
    expect_frame("init3", 32'h0800_0001);
    expect_frame("rr_ch1", CMDX | 32'h0011_1100);
    expect_frame("rr_ch2", CMDX | 32'h0022_2200);
    expect_frame("rr_ch6", CMDX | 32'h0066_6600);
    expect_frame("rr_ch1b", CMDX | 32'h0011_2300);
`ifdef DAC_SYNC_UPDATE_EN
    expect_frame("upd3", 32'h01F0_0000);
`endif
    expect_quiet("t3", 600);

    // Test 4: reset in the middle of the ch4 frame
    do_write(4, 12'h444);
    waited = 0;
    while (cs_n && waited < 100) begin @(negedge clk); waited++; end
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_cs_n", 32'(cs_n), 32'd1);
    check_val("midrst_sclk", 32'(sclk), 32'd0);
    check_val("midrst_mosi", 32'(mosi), 32'd0);
    check_val("midrst_init_done", 32'(init_done), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_frame("init4", 32'h0800_0001);
    expect_quiet("t4", 600);

    // Test 5: ch0 and ch7 (plus update-all frame when enabled)
    do_write(0, 12'h100);
    do_write(7, 12'hFFF);
    expect_frame("ch0", CMDX | 32'h0001_0000);
    expect_frame("ch7", CMDX | 32'h007F_FF00);
`ifdef DAC_SYNC_UPDATE_EN
    expect_frame("upd5", 32'h01F0_0000);
`endif
    expect_quiet("t5", 600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
